lcd_spi_ctrl: RTL
=================

Name: lcd_spi_ctrl

Overview:
- Parametrised successor to the Hack LCD write port: a 4-wire SPI transmitter for ILI9341-class panels.
- Memory-mapped from the Hack CPU with the same strobes: loadC (command byte), loadD8 (data byte) and loadD16 (data word).
- Differences from the previous block: a write FIFO decouples the CPU from SPI timing, SCK rate is configurable, and status is readable.
- Chip select is held across back-to-back frames.

Parameters:
- DIV, 1: SCK half-period in clk cycles (>=1); one bit = 2*DIV clk cycles.
- FIFO_DEPTH, 4: entries in the write FIFO (power of 2, >=2).
- CS_GAP, 2: minimum CS_n high time in clk cycles after a burst ends.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- loadC  in  1  enqueue command; in[7:0] sent with DC=0.
- loadD8  in  1  enqueue data byte; in[7:0] sent with DC=1.
- loadD16  in  1  enqueue data word; in[15:0] sent with DC=1.
- in  in  16  write data.
- out  out  16  status: [0] busy, [1] full, [2] overflow (sticky), [3] empty, [7:4] fill level, [15:8] zero.
- lcd_cs_n  out  1  panel chip select, active low.
- lcd_dc  out  1  0 = command, 1 = data.
- lcd_sck  out  1  SPI clock; mode 0, idles low.
- lcd_sdo  out  1  SPI MOSI, MSB first.

Behaviour:
- Reset: all state clears asynchronously.
  - lcd_cs_n=1, lcd_sck=0, lcd_sdo=0, lcd_dc=0.
  - FIFO empty; overflow=0; FSM to IDLE.
  - A frame in flight is abandoned with no partial completion.
- Enqueue: one write per clk.
  - If more than one load is high, priority is loadC > loadD16 > loadD8; the others are ignored.
  - Entry = {kind[1:0], in[15:0]}.
  - A write while full is dropped and sets overflow. Overflow clears only on reset.
- Simultaneous push and pop on a full FIFO: the push is accepted, because the pop frees the slot in the same cycle.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, GAP.
- IDLE: when the FIFO is non-empty, pop the entry into the shift register (8 or 16 bits) and enter SETUP.
- SETUP, DIV cycles: cs_n=0, dc per kind, sdo=MSB, sck=0.
- SCK_HI, DIV cycles: sck=1; the panel samples on the rising edge.
- SCK_LO, DIV cycles: sck=0; sdo advances to the next bit at entry.
- End of frame: after the last bit's SCK_HI, sck returns low.
  - If the FIFO is non-empty: pop and go to SETUP with cs_n held 0 (back-to-back frames); dc may change here.
  - Otherwise: go to GAP.
- GAP: cs_n=1 for CS_GAP cycles, then IDLE.
- Latency: a write at edge N gives cs_n=0 and valid sdo after edge N+2 when idle.
- Frame duration: 8-bit frame = DIV + 16*DIV cycles from SETUP start; 16-bit frame = DIV + 32*DIV.
- busy = FIFO non-empty OR state != IDLE.
- The bit counter and divider counter are internal. Divider width is clog2(DIV)+1; no wrap beyond DIV-1.

Optional Feature:
- Macro: LCD_REPEAT_EN.
- When defined:
  - Adds input loadR (1 bit). loadR captures in[15:0] into a repeat register rep (reset 0); loadR does not use the FIFO.
  - Each D16 entry is transmitted rep+1 times back-to-back with cs_n held, so rep=0xFFFF sends 65536 words. This is used for rectangle fills.
  - rep is sampled at pop. A loadR during a repeat burst affects only later entries.
  - busy stays 1 for the whole repeat burst.
- When undefined: no loadR port; each D16 entry is sent once.

Decomposition:
- Package lcd_pkg holds:
  - kind encoding: KIND_C=2'd0, KIND_D8=2'd1, KIND_D16=2'd2.
  - FSM state encoding.
  - status bit indices STAT_BUSY, STAT_FULL, STAT_OVF, STAT_EMPTY.
- Sub-module lcd_fifo: synchronous FIFO, parameters WIDTH=18 and DEPTH.
  - Ports: push/pop, full/empty, level.
  - Supports simultaneous push/pop.

Test Plan:
- loadC, in=6: cs_n falls 2 cycles later, dc=0, sdo bits 0000_0110 on 8 sck rising edges, then cs_n=1 for CS_GAP cycles and busy=0.
- loadD8 in=0x2C, then (DIV=1) loadD16 in=32123 one cycle later: a single cs_n low burst; 8 bits 0x2C then 16 bits 0x7D7B, dc=1 throughout, no CS gap between frames.
- Overflow (DEPTH=4, DIV=4): write every cycle until full=1, then one more write with in=0xAA. Required: overflow=1; 0xAA never appears on sdo; all earlier entries are sent in order.
- Priority: loadC and loadD16 high together with in=0x1234: exactly one 8-bit command frame with value 0x34 and dc=0.
- Reset mid-frame: rst_n low during bit 3 of a D16 frame. Required: cs_n=1 and sck=0 immediately, status reads 0x0008, and no further SCK edges after release.
- LCD_REPEAT_EN: loadR in=2, then loadD16 in=0xF800. Required: 3 words 0xF800 within one cs_n burst, 96*DIV+DIV cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the ILI9341-class SPI write port.
//   - entry kind encoding carried in the top two bits of each FIFO entry
//   - transmitter FSM state encoding
//   - bit positions of the memory-mapped status word
//   - loadKind(): resolves simultaneous strobes (loadC > loadD16 > loadD8)
package lcd_pkg;

  localparam logic [1:0] KIND_C   = 2'd0;
  localparam logic [1:0] KIND_D8  = 2'd1;
  localparam logic [1:0] KIND_D16 = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    GAP    = 3'd4
  } lcdState_t;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_EMPTY = 3;

  // Only meaningful when at least one strobe is high.
  function automatic logic [1:0] loadKind(input logic c, input logic d16);
    if (c) return KIND_C;
    if (d16) return KIND_D16;
    return KIND_D8;
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// lcd_fifo: synchronous write FIFO with first-word fall-through read.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      write request and entry
//   pop, dout      read request; dout always shows the oldest entry
//   full, empty    occupancy flags
//   level          number of stored entries (0..DEPTH)
// Handshake: a push is accepted when !full or when a pop is accepted in the
// same cycle (the pop frees the slot); a pop is accepted when !empty.
// Refused requests have no effect. DEPTH must be a power of two, >= 2.
module lcd_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rdPtr];

  // Storage carries no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_spi_ctrl.sv
// lcd_spi_ctrl: 4-wire SPI write port for ILI9341-class panels, driven by
// the Hack CPU strobes. Writes go into a FIFO; a small FSM shifts each entry
// out MSB first (SPI mode 0) and holds chip select low across back-to-back
// frames. All panel outputs are registered and follow the FSM state by one
// clock, so a write at edge N shows cs_n=0 and the first bit after edge N+2.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   loadC             enqueue in[7:0] as a command (dc=0)
//   loadD8            enqueue in[7:0] as data (dc=1)
//   loadD16           enqueue in[15:0] as data (dc=1)
//   loadR             (LCD_REPEAT_EN only) capture in[15:0] as repeat count
//   in[15:0]          write data
//   out[15:0]         status: [0] busy [1] full [2] overflow (sticky)
//                     [3] empty [7:4] fill level [15:8] zero
//   lcd_cs_n, lcd_dc, lcd_sck, lcd_sdo   panel SPI pins
// Build option: define LCD_REPEAT_EN to send each D16 entry rep+1 times
// inside one chip-select burst (rectangle fills).
module lcd_spi_ctrl
  import lcd_pkg::*;
#(
  parameter int DIV        = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loadC,
  input  logic        loadD8,
  input  logic        loadD16,
`ifdef LCD_REPEAT_EN
  input  logic        loadR,
`endif
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        lcd_cs_n,
  output logic        lcd_dc,
  output logic        lcd_sck,
  output logic        lcd_sdo
);

  localparam int DW = $clog2(DIV) + 1;
  localparam int GW = $clog2(CS_GAP + 1) + 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  lcdState_t     state;
  logic [DW-1:0] divCnt;
  logic [GW-1:0] gapCnt;
  logic [3:0]    bitCnt;
  logic [15:0]   shiftReg;
  logic          wide;
  logic          dcReg;
  logic          lastLo;
  logic          ovf;

  logic          wrReq;
  logic [17:0]   fifoDin;
  logic [17:0]   fifoDout;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [LW-1:0] fifoLevel;
  logic          popReq;
  logic          divDone;
  logic          gapDone;
  logic          active;
  logic [3:0]    lastBit;
  logic          busy;

`ifdef LCD_REPEAT_EN
  logic [15:0]   rep;
  logic [15:0]   repCnt;
  logic [15:0]   wordReg;
`endif

  assign wrReq   = loadC || loadD8 || loadD16;
  assign fifoDin = {loadKind(loadC, loadD16), in};

  assign divDone = (divCnt == DW'(DIV - 1));
  assign gapDone = (int'(gapCnt) + 1 >= CS_GAP);
  assign active  = (state == SETUP) || (state == SCK_HI) || (state == SCK_LO);
  assign lastBit = wide ? 4'd15 : 4'd7;

  // Pop from IDLE, or at the end of the final low phase of a frame so the
  // next frame follows with chip select still asserted.
  assign popReq = !fifoEmpty &&
                  ((state == IDLE) || (state == SCK_LO && divDone && lastLo));

  assign busy = !fifoEmpty || (state != IDLE);

  lcd_fifo #(
    .WIDTH (18),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wrReq),
    .din   (fifoDin),
    .pop   (popReq),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .level (fifoLevel)
  );

  // A write is lost only when the FIFO is full and nothing leaves this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (wrReq && fifoFull && !popReq) ovf <= 1'b1;
  end

`ifdef LCD_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep <= '0;
    else if (loadR) rep <= in;
  end
`endif

  always_comb begin
    out = '0;
    out[STAT_BUSY]  = busy;
    out[STAT_FULL]  = fifoFull;
    out[STAT_OVF]   = ovf;
    out[STAT_EMPTY] = fifoEmpty;
    out[7:4]        = 4'(fifoLevel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      divCnt   <= '0;
      gapCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      wide     <= 1'b0;
      dcReg    <= 1'b0;
      lastLo   <= 1'b0;
`ifdef LCD_REPEAT_EN
      repCnt   <= '0;
      wordReg  <= '0;
`endif
      lcd_cs_n <= 1'b1;
      lcd_sck  <= 1'b0;
      lcd_sdo  <= 1'b0;
      lcd_dc   <= 1'b0;
    end else begin
      lcd_cs_n <= !active;
      lcd_sck  <= (state == SCK_HI);
      lcd_sdo  <= active && shiftReg[15];
      lcd_dc   <= dcReg;

      if (popReq) begin
        // Shift register is MSB-aligned: byte entries sit in the upper half.
        state    <= SETUP;
        divCnt   <= '0;
        bitCnt   <= '0;
        lastLo   <= 1'b0;
        wide     <= (fifoDout[17:16] == KIND_D16);
        dcReg    <= (fifoDout[17:16] != KIND_C);
        shiftReg <= (fifoDout[17:16] == KIND_D16) ? fifoDout[15:0]
                                                   : {fifoDout[7:0], 8'h00};
`ifdef LCD_REPEAT_EN
        wordReg  <= fifoDout[15:0];
        repCnt   <= (fifoDout[17:16] == KIND_D16) ? rep : 16'd0;
`endif
      end else begin
        case (state)
          IDLE: begin
            divCnt <= '0;
          end
          SETUP: begin
            if (divDone) begin
              divCnt <= '0;
              state  <= SCK_HI;
            end else begin
              divCnt <= divCnt + 1'b1;
            end
          end
          SCK_HI: begin
            if (divDone) begin
              divCnt <= '0;
              state  <= SCK_LO;
              if (bitCnt == lastBit) begin
`ifdef LCD_REPEAT_EN
                // Repeats reload the word and continue without a SETUP phase.
                if (repCnt != 16'd0) begin
                  repCnt   <= repCnt - 1'b1;
                  shiftReg <= wordReg;
                  bitCnt   <= '0;
                end else begin
                  lastLo <= 1'b1;
                end
`else
                lastLo <= 1'b1;
`endif
              end else begin
                shiftReg <= {shiftReg[14:0], 1'b0};
                bitCnt   <= bitCnt + 1'b1;
              end
            end else begin
              divCnt <= divCnt + 1'b1;
            end
          end
          SCK_LO: begin
            if (divDone) begin
              divCnt <= '0;
              if (lastLo) begin
                lastLo <= 1'b0;
                gapCnt <= '0;
                state  <= GAP;
              end else begin
                state <= SCK_HI;
              end
            end else begin
              divCnt <= divCnt + 1'b1;
            end
          end
          GAP: begin
            if (gapDone) state <= IDLE;
            else gapCnt <= gapCnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
